// File: rtl/calc_display_pkg.sv
// Shared display types and constants for the calculator's 7-segment output.
// Segment codes are active-low: bit7 = DP, bits6..0 = g..a.
package calc_display_pkg;

    typedef enum logic [7:0] {
        SEG_ZERO    = 8'b1100_0000,
        SEG_ONE     = 8'b1111_1001,
        SEG_TWO     = 8'b1010_0100,
        SEG_THREE   = 8'b1011_0000,
        SEG_FOUR    = 8'b1001_1001,
        SEG_FIVE    = 8'b1001_0010,
        SEG_SIX     = 8'b1000_0010,
        SEG_SEVEN   = 8'b1111_1000,
        SEG_EIGHT   = 8'b1000_0000,
        SEG_NINE    = 8'b1001_0000,
        SEG_E       = 8'b1000_0110,
        SEG_MINUS   = 8'b1011_1111,
        SEG_P_ZERO  = 8'b0100_0000,
        SEG_P_ONE   = 8'b0111_1001,
        SEG_P_TWO   = 8'b0010_0100,
        SEG_P_THREE = 8'b0011_0000,
        SEG_P_FOUR  = 8'b0001_1001,
        SEG_P_FIVE  = 8'b0001_0010,
        SEG_P_SIX   = 8'b0000_0010,
        SEG_P_SEVEN = 8'b0111_1000,
        SEG_P_EIGHT = 8'b0000_0000,
        SEG_P_NINE  = 8'b0001_0000
    } segment_t;

    localparam logic [3:0] ANODE_UNITS     = 4'b1110;
    localparam logic [3:0] ANODE_TENS      = 4'b1101;
    localparam logic [3:0] ANODE_HUNDREDS  = 4'b1011;
    localparam logic [3:0] ANODE_THOUSANDS = 4'b0111;

    localparam int DISPLAY_MIN = -999;
    localparam int DISPLAY_MAX = 9999;

    typedef struct packed {
        logic            neg;
        logic            err;
        logic            point;
        logic [3:0][3:0] digits;
    } display_t;

    function automatic logic [3:0] anode_select(logic [1:0] idx);
        case (idx)
            2'd0:    return ANODE_UNITS;
            2'd1:    return ANODE_TENS;
            2'd2:    return ANODE_HUNDREDS;
            default: return ANODE_THOUSANDS;
        endcase
    endfunction

    function automatic segment_t digit_to_segment(logic [3:0] digit, logic point);
        segment_t code;
        case (digit)
            4'd1:    code = SEG_ONE;
            4'd2:    code = SEG_TWO;
            4'd3:    code = SEG_THREE;
            4'd4:    code = SEG_FOUR;
            4'd5:    code = SEG_FIVE;
            4'd6:    code = SEG_SIX;
            4'd7:    code = SEG_SEVEN;
            4'd8:    code = SEG_EIGHT;
            4'd9:    code = SEG_NINE;
            default: code = SEG_ZERO;
        endcase
        if (point) code = segment_t'({1'b0, code[6:0]});
        return code;
    endfunction

    // Error overrides everything; MINUS occupies the thousands slot.
    function automatic segment_t display_segment(display_t disp, logic [1:0] idx);
        if (disp.err) return (idx == 2'd0) ? SEG_E : SEG_ZERO;
        if (disp.neg && idx == 2'd3) return SEG_MINUS;
        return digit_to_segment(disp.digits[idx], disp.point && idx == 2'd2);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift per clock, the first applied on start.
// done pulses for one cycle once all WIDTH shifts are in the BCD register.
module bin2bcd_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] magnitude,
    output logic             done,
    output logic [3:0][3:0]  digits
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_q;
    logic [15:0]      bcd_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [WIDTH+15:0] dabble(logic [15:0] bcd, logic [WIDTH-1:0] bin);
        logic [15:0] adj;
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj, bin} << 1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {bcd_q, bin_q} <= dabble(16'h0000, magnitude);
                cnt_q          <= CNT_W'(WIDTH - 1);
                done           <= (WIDTH == 1);
            end else if (cnt_q != '0) begin
                {bcd_q, bin_q} <= dabble(bcd_q, bin_q);
                cnt_q          <= cnt_q - CNT_W'(1);
                done           <= (cnt_q == CNT_W'(1));
            end
        end
    end

    assign digits = bcd_q;

endmodule

// File: rtl/seg7_display_driver.sv
// Signed value -> sign/BCD display register -> multiplexed common-anode 7-seg scan.
//
//   state  | meaning
//   IDLE   | display stable, waiting for load
//   RANGE  | |value| and error flag computed, BCD engine started
//   SHIFT  | double-dabble running
//   COMMIT | display register written atomically
module seg7_display_driver
    import calc_display_pkg::*;
#(
    parameter int VALUE_WIDTH = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   err,
    input  logic                   point_en,
    output logic                   busy,
    output logic [3:0]             anodes,
    output logic [7:0]             segments
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, RANGE, SHIFT, COMMIT} state_t;

    state_t state_q, state_d;
    logic   start, commit, bcd_done;

    logic signed [VALUE_WIDTH-1:0] value_q;
    logic                          err_in_q, point_q, neg_q, range_err_q;
    logic signed [31:0]            value_ext;
    logic [VALUE_WIDTH-1:0]        magnitude;
    logic                          out_of_range;
    logic [3:0][3:0]               bcd_digits;
    display_t                      disp_q;

    logic [CNT_W-1:0] refresh_q;
    logic [1:0]       scan_q;
    logic [3:0]       anodes_q;
    segment_t         seg_q;

    assign value_ext    = 32'(value_q);
    assign magnitude    = value_q[VALUE_WIDTH-1] ? VALUE_WIDTH'(-value_q) : VALUE_WIDTH'(value_q);
    assign out_of_range = (value_ext < DISPLAY_MIN) || (value_ext > DISPLAY_MAX);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A load in any state restarts from the new value and cancels a pending commit.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE:   if (load) state_d = RANGE;
            RANGE:  begin start = 1'b1; state_d = SHIFT; end
            SHIFT:  if (bcd_done) state_d = COMMIT;
            COMMIT: begin commit = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = RANGE;
            start   = 1'b0;
            commit  = 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

    bin2bcd_seq #(.WIDTH(VALUE_WIDTH)) u_bin2bcd (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .magnitude (magnitude),
        .done      (bcd_done),
        .digits    (bcd_digits)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q     <= '0;
            err_in_q    <= 1'b0;
            point_q     <= 1'b0;
            neg_q       <= 1'b0;
            range_err_q <= 1'b0;
            disp_q      <= '0;
        end else begin
            if (load) begin
                value_q  <= value;
                err_in_q <= err;
                point_q  <= point_en;
            end
            if (start) begin
                neg_q       <= value_q[VALUE_WIDTH-1];
                range_err_q <= err_in_q || out_of_range;
            end
            if (commit) begin
                disp_q <= '{neg:    neg_q && !range_err_q,
                            err:    range_err_q,
                            point:  point_q && !range_err_q,
                            digits: bcd_digits};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            scan_q    <= 2'd0;
            anodes_q  <= ANODE_UNITS;
            seg_q     <= SEG_ZERO;
        end else begin
            if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_q <= '0;
                scan_q    <= scan_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + CNT_W'(1);
            end
            anodes_q <= anode_select(scan_q);
            seg_q    <= display_segment(disp_q, scan_q);
        end
    end

    assign anodes   = anodes_q;
    assign segments = seg_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Self-checking bench for seg7_display_driver against an arithmetic display model.
module tb_seg7_display_driver;
    localparam int VW = 16;
    localparam int RD = 4;
    localparam logic [7:0] DIGIT_SEG [10] = '{8'b11000000, 8'b11111001, 8'b10100100,
        8'b10110000, 8'b10011001, 8'b10010010, 8'b10000010, 8'b11111000, 8'b10000000,
        8'b10010000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [VW-1:0] value = '0;
    logic          err = 1'b0;
    logic          point_en = 1'b0;
    logic          busy;
    logic [3:0]    anodes;
    logic [7:0]    segments;

    int n_cmp = 0;
    int n_bad = 0;

    // model: shown value, pending value, timing bookkeeping
    int m_val = 0;
    bit m_err = 0, m_pt = 0;
    int p_val = 0;
    bit p_err = 0, p_pt = 0, p_valid = 0;
    int load_edge = 0;
    int edge_no = 0;

    always #5 clk = ~clk;

    seg7_display_driver #(.VALUE_WIDTH(VW), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .err      (err),
        .point_en (point_en),
        .busy     (busy),
        .anodes   (anodes),
        .segments (segments)
    );

    function automatic logic [7:0] exp_seg(int v, bit e, bit p, logic [3:0] an);
        int pos, mag, d;
        logic [7:0] code;
        case (an)
            4'b1110: pos = 0;
            4'b1101: pos = 1;
            4'b1011: pos = 2;
            4'b0111: pos = 3;
            default: return 8'h00;
        endcase
        if (e || v < -999 || v > 9999) return (pos == 0) ? 8'b10000110 : 8'b11000000;
        if (v < 0 && pos == 3) return 8'b10111111;
        mag  = (v < 0) ? -v : v;
        d    = (mag / (10 ** pos)) % 10;
        code = DIGIT_SEG[d];
        if (p && pos == 2) code[7] = 1'b0;
        return code;
    endfunction

    function automatic logic [3:0] exp_anode();
        if (edge_no == 0) return 4'b1110;
        case (((edge_no - 1) / RD) % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic exp_busy();
        return p_valid && (edge_no - load_edge) < 18;
    endfunction

    function automatic logic [12:0] exp_out();
        return {exp_busy(), exp_anode(), exp_seg(m_val, m_err, m_pt, exp_anode())};
    endfunction

    // One clock edge: update the model from the inputs the DUT samples on it.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            edge_no = 0; m_val = 0; m_err = 0; m_pt = 0; p_valid = 0;
        end else begin
            edge_no++;
            if (p_valid && edge_no - load_edge == 19) begin
                m_val = p_val; m_err = p_err; m_pt = p_pt; p_valid = 0;
            end
            if (load) begin
                p_val = $signed(value); p_err = err; p_pt = point_en;
                p_valid = 1; load_edge = edge_no;
            end
        end
        #1;
        load = 1'b0;
    endtask

    task automatic drive_load(int v, bit e, bit p);
        value = VW'(v); err = e; point_en = p; load = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_cmp++;
            if ({busy, anodes, segments} !== {1'b0, 4'b1110, 8'b11000000}) begin
                n_bad++;
                $display("FAIL reset: busy/anodes/segments got %b/%b/%b want 0/1110/11000000",
                         busy, anodes, segments);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan_idle();
        for (int i = 0; i < 20; i++) begin
            advance();
            n_cmp++;
            if ({busy, anodes, segments} !== exp_out()) begin
                n_bad++;
                $display("FAIL scan_idle edge %0d: got %b/%b/%b want %b", edge_no, busy, anodes,
                         segments, exp_out());
            end
        end
    endtask

    task automatic test_convert();
        int busy_cycles = 0;
        bit seen = 0;
        drive_load(1234, 0, 0);
        for (int i = 0; i < 40; i++) begin
            advance();
            if (busy === 1'b1) busy_cycles++;
            n_cmp++;
            if ({busy, anodes, segments} !== exp_out()) begin
                n_bad++;
                $display("FAIL convert_1234 edge %0d: got %b/%b/%b want %b", edge_no, busy,
                         anodes, segments, exp_out());
            end
            if (i >= 19 && anodes === 4'b0111 && !seen) begin
                seen = 1;
                n_cmp++;
                if (segments !== 8'b11111001) begin
                    n_bad++;
                    $display("FAIL convert_thousands: got %b want 11111001", segments);
                end
            end
        end
        n_cmp++;
        if (busy_cycles != 18 || !seen) begin
            n_bad++;
            $display("FAIL busy_length: got %0d cycles (thousands seen %0d) want 18 (1)",
                     busy_cycles, seen);
        end
    endtask

    task automatic test_negative_point();
        int vals [2] = '{-7, 1500};
        for (int t = 0; t < 2; t++) begin
            drive_load(vals[t], 0, t == 1);
            for (int i = 0; i < 36; i++) begin
                advance();
                n_cmp++;
                if ({busy, anodes, segments} !== exp_out()) begin
                    n_bad++;
                    $display("FAIL neg_point %0d edge %0d: got %b/%b/%b want %b", vals[t],
                             edge_no, busy, anodes, segments, exp_out());
                end
            end
        end
    endtask

    task automatic test_error();
        int vals [3] = '{225, 10000, -1000};
        for (int t = 0; t < 3; t++) begin
            drive_load(vals[t], t == 0, 1);
            for (int i = 0; i < 36; i++) begin
                advance();
                n_cmp++;
                if ({busy, anodes, segments} !== exp_out()) begin
                    n_bad++;
                    $display("FAIL error %0d edge %0d: got %b/%b/%b want %b", vals[t], edge_no,
                             busy, anodes, segments, exp_out());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit saw_fifteen = 0;
        drive_load(15, 0, 0);
        for (int i = 0; i < 44; i++) begin
            if (i == 4) drive_load(225, 0, 0);
            advance();
            if (anodes === 4'b1101 && segments === 8'b11111001) saw_fifteen = 1;
            n_cmp++;
            if ({busy, anodes, segments} !== exp_out()) begin
                n_bad++;
                $display("FAIL back_to_back edge %0d: got %b/%b/%b want %b", edge_no, busy,
                         anodes, segments, exp_out());
            end
        end
        n_cmp++;
        if (saw_fifteen) begin
            n_bad++;
            $display("FAIL stale_value: got 15 displayed want never");
        end
    endtask

    task automatic test_reset_mid();
        drive_load(4321, 0, 1);
        for (int i = 0; i < 6; i++) advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        n_cmp++;
        if ({busy, anodes, segments} !== {1'b0, 4'b1110, 8'b11000000}) begin
            n_bad++;
            $display("FAIL reset_mid: got %b/%b/%b want 0/1110/11000000", busy, anodes, segments);
        end
        for (int i = 0; i < 40; i++) begin
            advance();
            n_cmp++;
            if ({busy, anodes, segments} !== exp_out()) begin
                n_bad++;
                $display("FAIL after_reset_mid edge %0d: got %b/%b/%b want %b", edge_no, busy,
                         anodes, segments, exp_out());
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int v, gap;
            v   = int'($urandom_range(11400)) - 1200;
            gap = int'($urandom_range(30, 1));
            drive_load(v, $urandom_range(7) == 0, $urandom_range(1) == 1);
            for (int i = 0; i < gap + ((t == 39) ? 40 : 0); i++) begin
                advance();
                n_cmp++;
                if ({busy, anodes, segments} !== exp_out()) begin
                    n_bad++;
                    $display("FAIL random v=%0d edge %0d: got %b/%b/%b want %b", p_val, edge_no,
                             busy, anodes, segments, exp_out());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_idle();
        test_convert();
        test_negative_point();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
